lane_packer: RTL
================

# lane_packer

Downstream consumer of one crossbar output lane. It accepts WIDTH-bit words on the lane's valid/q/stall handshake and packs PACK consecutive words into one wide output word for the wide consumer stage, such as the memory-write or reduction path. One instance sits behind each crossbar output port. The block is double-buffered: a pack register and an output register. It raises the lane's stall only when both buffers are occupied.

## Interface
Parameters:
- WIDTH, 8, bits per lane word (matches crossbar WIDTH)
- PACK, 4, lane words per packed output word, ≥2
- CNT_WIDTH, log2(PACK)+1, width of the word counter and of `count`

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- valid_in  in  1  lane word present (crossbar `valid[n]`)
- d  in  WIDTH  lane word (crossbar q slice n)
- stall_out  out  1  backpressure to lane (crossbar `stall[n]`)
- valid  out  1  packed word present
- q  out  WIDTH*PACK  packed word; word 0 in bits [WIDTH-1:0]
- count  out  CNT_WIDTH  number of meaningful words in q
- stall  in  1  downstream backpressure
- flush  in  1  only with LANE_PACKER_FLUSH_EN; emit partial word

## Operation
- Lane transfer: valid_in=1 && stall_out=0 on the same cycle. Word goes to pack slot `cnt`, and `cnt` increments.
- Output transfer: valid=1 && stall=0. The output register empties at that edge unless it is reloaded at the same edge.
- `out_free` = !valid || !stall.
- Pack complete: a lane transfer with cnt==PACK-1.
  - If out_free, the packed word, including the incoming d, loads the output register at that edge. valid=1, count=PACK, cnt=0.
  - Otherwise pack_full←1 and cnt←0. The packed word is retained.
- stall_out = pack_full. This is a combinational function of the register only, with no path from stall or valid_in.
- pack_full=1 and out_free: the pack register moves to output at the edge and pack_full←0.
- Output register holds q/count stable while valid && stall.
- Unused slots in q are always zero.
- States are implied by (cnt, pack_full, valid):
  - FILL: pack_full=0.
  - FULL: pack_full=1.
  - Output register occupancy is independent.

## Timing
- Reset values: valid=0, q=0, count=0, stall_out=0, cnt=0, pack_full=0. Reset takes effect immediately and asynchronously; mid-fill partial data is discarded.
- Latency: the last word is accepted at edge k, and valid is high from edge k. This is zero extra cycles when out_free.
- With stall held low, sustained throughput is 1 lane word/cycle, i.e. 1 packed word per PACK cycles, and stall_out never asserts.
- With stall high:
  - One packed word is held in the output register.
  - The next PACK words fill the pack register, then stall_out=1.
  - On the first cycle with stall=0, the output drains and the pack register moves to output at that same edge. stall_out deasserts the following cycle.
- The lane must hold d/valid_in while stall_out=1. Words presented during stall_out=1 are not accepted.

## Configuration
- LANE_PACKER_FLUSH_EN defined: the `flush` port exists.
  - If flush=1, pack_full=0, and (cnt>0 or a lane transfer occurs this cycle), the partial word moves to output when out_free.
  - The partial word includes any word transferred that same cycle.
  - count = words held; upper slots are zero; cnt←0.
  - If not out_free, the partial word is marked pack_full and emitted later, with count preserved.
  - flush with cnt=0 and no transfer is ignored.
  - flush while pack_full=1 is ignored.
- LANE_PACKER_FLUSH_EN undefined: there is no flush port, and count is PACK whenever valid=1 (0 after reset).

## Test plan
- Reset: assert rst mid-fill (cnt=2) -> valid=0, q=0, count=0, stall_out=0 immediately; the next 4 words produce a clean packed word.
- Streaming, PACK=4, WIDTH=8, stall=0: feed 0x01..0x08 on consecutive cycles -> valid for one cycle after edge 4 with q=0x04030201 and after edge 8 with q=0x08070605; stall_out stays 0.
- Backpressure: stall=1 and feed 12 words -> two packed words are accepted, then stall_out=1 with the third word held. Release stall -> q=0x04030201 drains, and the next word 0x08070605 appears the following cycle. No word is lost or duplicated.
- Simultaneous completion and drain: the output drains on the same cycle the 4th word arrives -> the new word loads directly and valid stays high.
- Flush (LANE_PACKER_FLUSH_EN): feed 0xAA, 0xBB, then flush with 0xCC transferring in the same cycle -> q=0x00CCBBAA, count=3.
- Flush while blocked: stall=1 with the output occupied and flush at cnt=2 -> stall_out=1. After release, the partial word is emitted with count=2.

Source files
------------

// File: rtl/lane_packer.sv
// lane_packer: packs PACK consecutive lane words into one wide word behind a
// crossbar output port. Optional partial-word flush under `LANE_PACKER_FLUSH_EN`.
module lane_packer #(
    parameter int WIDTH     = 8,
    parameter int PACK      = 4,
    parameter int CNT_WIDTH = $clog2(PACK) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [WIDTH-1:0]      d,
    output logic                  stall_out,
    output logic                  valid,
    output logic [WIDTH*PACK-1:0] q,
    output logic [CNT_WIDTH-1:0]  count,
    input  logic                  stall
`ifdef LANE_PACKER_FLUSH_EN
    ,
    input  logic                  flush
`endif
);

    localparam logic [CNT_WIDTH-1:0] LAST_SLOT = CNT_WIDTH'(PACK - 1);

    logic [WIDTH*PACK-1:0] pack_q, pack_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  pack_full_q, pack_full_d;
    logic [CNT_WIDTH-1:0]  pack_cnt_q, pack_cnt_d;
    logic [WIDTH*PACK-1:0] out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0]  out_cnt_q, out_cnt_d;

    logic                  lane_xfer;
    logic                  out_free;
    logic                  complete;
    logic                  flush_go;
    logic                  emit;
    logic [CNT_WIDTH-1:0]  emit_cnt;
    logic [WIDTH*PACK-1:0] pack_next;

    assign stall_out = pack_full_q;
    assign valid     = out_valid_q;
    assign q         = out_q;
    assign count     = out_cnt_q;

    assign lane_xfer = valid_in && !pack_full_q;
    assign out_free  = !out_valid_q || !stall;
    assign complete  = lane_xfer && (cnt_q == LAST_SLOT);
    assign emit_cnt  = cnt_q + CNT_WIDTH'(lane_xfer);

`ifdef LANE_PACKER_FLUSH_EN
    assign flush_go = flush && !pack_full_q && ((cnt_q != '0) || lane_xfer);
`else
    assign flush_go = 1'b0;
`endif

    assign emit = complete || flush_go;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pack_next = pack_q;
        if (lane_xfer) begin
            pack_next[int'(cnt_q)*WIDTH +: WIDTH] = d;
        end
    end

    always_comb begin
        pack_d      = pack_q;
        cnt_d       = cnt_q;
        pack_full_d = pack_full_q;
        pack_cnt_d  = pack_cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_cnt_d   = out_cnt_q;

        if (out_valid_q && !stall) begin
            out_valid_d = 1'b0;
        end

        if (pack_full_q) begin
            // Held word moves to output as soon as the output frees; lane is stalled meanwhile.
            if (out_free) begin
                out_d       = pack_q;
                out_cnt_d   = pack_cnt_q;
                out_valid_d = 1'b1;
                pack_d      = '0;
                pack_full_d = 1'b0;
                pack_cnt_d  = '0;
            end
        end else if (emit) begin
            cnt_d = '0;
            if (out_free) begin
                out_d       = pack_next;
                out_cnt_d   = emit_cnt;
                out_valid_d = 1'b1;
                pack_d      = '0;
            end else begin
                pack_d      = pack_next;
                pack_full_d = 1'b1;
                pack_cnt_d  = emit_cnt;
            end
        end else if (lane_xfer) begin
            pack_d = pack_next;
            cnt_d  = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Pack register is reset to zero because unused slots must read as zero when emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_q      <= '0;
            cnt_q       <= '0;
            pack_full_q <= 1'b0;
            pack_cnt_q  <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_cnt_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together.
            pack_q      <= pack_d;
            cnt_q       <= cnt_d;
            pack_full_q <= pack_full_d;
            pack_cnt_q  <= pack_cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

endmodule
